// File: rtl/sent_tx_pulse_gen.sv
// SENT transmit pulse generator: SETUP/LOW/HIGH sequencing of sync, nibble and pause pulses.
// Optional SENT_TX_CONST_FRAME_EN: pause length pads the frame to FRAME_TICKS.
module sent_tx_pulse_gen #(
  parameter int unsigned CLK_PER_TICK = 4,
  parameter int unsigned LOW_TICKS    = 5,
  parameter int unsigned PAUSE_TICKS  = 12,
  parameter int unsigned FRAME_TICKS  = 300
) (
  input  logic       clk_tx,
  input  logic       reset_tx,
  input  logic       sync,
  input  logic       pulse,
  input  logic       pause,
  input  logic [3:0] data_nibble,
  output logic       sent_out,
  output logic       pulse_done,
  output logic       busy,
  output logic       cmd_err
);

  localparam logic [17:0] LowCycles = 18'(LOW_TICKS * CLK_PER_TICK);

  typedef enum logic [1:0] {StIdle, StSetup, StLow, StHigh} state_e;

  state_e      r_state;
  logic [17:0] r_cnt;
  logic [9:0]  r_n;
  logic        r_sent_out;
  logic        r_pulse_done;
  logic        r_cmd_err;

  logic        w_any_req;
  logic        w_multi_req;
  logic [9:0]  w_pause_ticks;
  logic [9:0]  w_n_sel;
  logic [17:0] w_high_last;

  assign w_any_req   = sync | pulse | pause;
  assign w_multi_req = (sync & pulse) | (sync & pause) | (pulse & pause);

`ifdef SENT_TX_CONST_FRAME_EN
  logic [9:0]  r_frame_ticks;
  logic        r_frame_valid;
  logic [10:0] w_frame_sum;
  logic        w_sample;

  assign w_sample    = (r_state == StSetup) && (r_cnt == 18'd0) && w_any_req;
  assign w_frame_sum = {1'b0, r_frame_ticks} + {1'b0, w_n_sel};

  always_comb begin
    w_pause_ticks = 10'(PAUSE_TICKS);
    if (r_frame_valid) begin
      if (32'(r_frame_ticks) + 32'd12 >= FRAME_TICKS) begin
        w_pause_ticks = 10'd12;
      end else if (FRAME_TICKS - 32'(r_frame_ticks) > 32'd768) begin
        w_pause_ticks = 10'd768;
      end else begin
        w_pause_ticks = 10'(FRAME_TICKS - 32'(r_frame_ticks));
      end
    end
  end

  // Frame ticks accumulate the latched length of every pulse since the last sync.
  always_ff @(posedge clk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      r_frame_ticks <= 10'd0;
      r_frame_valid <= 1'b0;
    end else if (w_sample) begin
      if (sync) begin
        r_frame_ticks <= 10'd56;
        r_frame_valid <= 1'b1;
      end else begin
        r_frame_ticks <= w_frame_sum[10] ? 10'h3ff : w_frame_sum[9:0];
      end
    end
  end
`else
  assign w_pause_ticks = 10'(PAUSE_TICKS);
`endif

  always_comb begin
    if (sync) begin
      w_n_sel = 10'd56;
    end else if (pause) begin
      w_n_sel = w_pause_ticks;
    end else begin
      w_n_sel = 10'd12 + {6'd0, data_nibble};
    end
  end

  // HIGH length minus one; SETUP's 3 cycles are charged to the pulse total.
  assign w_high_last = 18'(r_n) * 18'(CLK_PER_TICK) - LowCycles - 18'd4;

  always_ff @(posedge clk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      r_state      <= StIdle;
      r_cnt        <= 18'd0;
      r_n          <= 10'd0;
      r_sent_out   <= 1'b1;
      r_pulse_done <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_pulse_done <= 1'b0;
      r_cmd_err    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state <= StSetup;
            r_cnt   <= 18'd2;
          end
        end
        StSetup: begin
          if (r_cnt != 18'd0) begin
            r_cnt <= r_cnt - 18'd1;
          end else if (!w_any_req) begin
            r_state <= StIdle;
          end else begin
            r_n        <= w_n_sel;
            r_cmd_err  <= w_multi_req;
            r_state    <= StLow;
            r_sent_out <= 1'b0;
            r_cnt      <= LowCycles - 18'd1;
          end
        end
        StLow: begin
          if (r_cnt != 18'd0) begin
            r_cnt <= r_cnt - 18'd1;
          end else begin
            r_state      <= StHigh;
            r_sent_out   <= 1'b1;
            r_cnt        <= w_high_last;
            r_pulse_done <= (w_high_last == 18'd0);
          end
        end
        StHigh: begin
          if (r_cnt != 18'd0) begin
            r_cnt        <= r_cnt - 18'd1;
            r_pulse_done <= (r_cnt == 18'd1);
          end else begin
            r_state <= StSetup;
            r_cnt   <= 18'd2;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign sent_out   = r_sent_out;
  assign pulse_done = r_pulse_done;
  assign cmd_err    = r_cmd_err;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// Directed bench for sent_tx_pulse_gen at default parameters (CLK_PER_TICK=4, LOW_TICKS=5).
module tb_sent_tx_pulse_gen;

  logic       clk_tx = 1'b0;
  logic       reset_tx = 1'b1;
  logic       sync = 1'b0;
  logic       pulse = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] data_nibble = 4'd0;
  logic       sent_out;
  logic       pulse_done;
  logic       busy;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;

  // Monitor state, sampled on the falling clock edge.
  int   cyc = 0;
  int   last_fall = 0;
  int   pd_cnt = 0;
  int   ce_cnt = 0;
  int   ce_run = 0;
  int   ce_max = 0;
  int   lens[$];
  int   lows[$];
  int   falls[$];
  logic prev_out = 1'b1;

  sent_tx_pulse_gen dut (
    .clk_tx      (clk_tx),
    .reset_tx    (reset_tx),
    .sync        (sync),
    .pulse       (pulse),
    .pause       (pause),
    .data_nibble (data_nibble),
    .sent_out    (sent_out),
    .pulse_done  (pulse_done),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  always #5 clk_tx = ~clk_tx;

  always @(negedge clk_tx) begin
    cyc++;
    if (prev_out && !sent_out) begin
      last_fall = cyc;
      falls.push_back(cyc);
    end
    if (!prev_out && sent_out && !reset_tx) lows.push_back(cyc - last_fall);
    prev_out = sent_out;
    if (pulse_done) begin
      pd_cnt++;
      lens.push_back(cyc + 4 - last_fall);
    end
    if (cmd_err) begin
      ce_cnt++;
      ce_run++;
      if (ce_run > ce_max) ce_max = ce_run;
    end else begin
      ce_run = 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic req(input logic s, input logic p, input logic pa, input logic [3:0] nib);
    sync = s;
    pulse = p;
    pause = pa;
    data_nibble = nib;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = pd_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_tx);
      #1;
      if (pd_cnt != start) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_done: no pulse_done within %0d cycles", budget);
  endtask

  task automatic go_idle();
    req(1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_tx);
      #1;
      if (!busy) return;
    end
    checks++;
    errors++;
    $display("FAIL go_idle: busy still %0b, required 0", busy);
  endtask

  task automatic clear_logs();
    lens.delete();
    lows.delete();
    falls.delete();
  endtask

  task automatic test_reset();
    reset_tx = 1'b1;
    sync = 1'b1;
    repeat (3) @(negedge clk_tx);
    #1;
    checks++; if (sent_out !== 1'b1) begin errors++; $display("FAIL reset_sent_out: got %b want 1", sent_out); end
    checks++; if (pulse_done !== 1'b0) begin errors++; $display("FAIL reset_pulse_done: got %b want 0", pulse_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
    sync = 1'b0;
    reset_tx = 1'b0;
    repeat (3) @(negedge clk_tx);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy %b want 0", busy); end
  endtask

  task automatic test_sync_nibble();
    int p0;
    clear_logs();
    p0 = pd_cnt;
    req(1'b1, 1'b0, 1'b0, 4'd0);
    wait_done(400);
    req(1'b0, 1'b1, 1'b0, 4'd0);
    wait_done(400);
    go_idle();
    checks++; if (lens[0] !== 224) begin errors++; $display("FAIL sync_len: got %0d want 224", lens[0]); end
    checks++; if (lens[1] !== 48) begin errors++; $display("FAIL nib0_len: got %0d want 48", lens[1]); end
    checks++; if (lows[0] !== 20) begin errors++; $display("FAIL low_len: got %0d want 20", lows[0]); end
    checks++; if (falls[1] - falls[0] !== 224) begin errors++; $display("FAIL sync_fall_spacing: got %0d want 224", falls[1] - falls[0]); end
    checks++; if (pd_cnt - p0 !== 2) begin errors++; $display("FAIL sync_pd_count: got %0d want 2", pd_cnt - p0); end
  endtask

  task automatic test_frame();
    int          p0;
    int          exp_len[9] = '{224, 108, 48, 52, 56, 60, 64, 68, 88};
    logic [3:0]  nibs[8] = '{4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hA};
    clear_logs();
    p0 = pd_cnt;
    req(1'b1, 1'b0, 1'b0, 4'd0);
    wait_done(400);
    for (int i = 0; i < 8; i++) begin
      req(1'b0, 1'b1, 1'b0, nibs[i]);
      wait_done(200);
    end
    req(1'b0, 1'b0, 1'b0, 4'd0);
    repeat (3) @(negedge clk_tx);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_setup_busy: got %b want 1", busy); end
    @(negedge clk_tx);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_end_busy: got %b want 0", busy); end
    checks++; if (sent_out !== 1'b1) begin errors++; $display("FAIL frame_end_line: got %b want 1", sent_out); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (lens[i] !== exp_len[i]) begin
        errors++;
        $display("FAIL frame_len[%0d]: got %0d want %0d", i, lens[i], exp_len[i]);
      end
    end
    checks++; if (pd_cnt - p0 !== 9) begin errors++; $display("FAIL frame_pd_count: got %0d want 9", pd_cnt - p0); end
  endtask

  task automatic test_pause();
    int exp_pause;
`ifdef SENT_TX_CONST_FRAME_EN
    exp_pause = 400;
`else
    exp_pause = 48;
`endif
    clear_logs();
    req(1'b1, 1'b0, 1'b0, 4'd0);
    wait_done(400);
    for (int i = 0; i < 8; i++) begin
      req(1'b0, 1'b1, 1'b0, 4'd6);
      wait_done(200);
    end
    req(1'b0, 1'b0, 1'b1, 4'd0);
    wait_done(4000);
    go_idle();
    checks++; if (lens[1] !== 72) begin errors++; $display("FAIL nib6_len: got %0d want 72", lens[1]); end
    checks++; if (lens[9] !== exp_pause) begin errors++; $display("FAIL pause_len: got %0d want %0d", lens[9], exp_pause); end
  endtask

  task automatic test_cmd_err();
    int c0;
    int exp_pp;
`ifdef SENT_TX_CONST_FRAME_EN
    exp_pp = 976;
`else
    exp_pp = 48;
`endif
    clear_logs();
    c0 = ce_cnt;
    ce_max = 0;
    req(1'b1, 1'b1, 1'b0, 4'd3);
    wait_done(400);
    go_idle();
    checks++; if (lens[0] !== 224) begin errors++; $display("FAIL err_sync_len: got %0d want 224", lens[0]); end
    checks++; if (ce_cnt - c0 !== 1) begin errors++; $display("FAIL err_count: got %0d want 1", ce_cnt - c0); end
    checks++; if (ce_max !== 1) begin errors++; $display("FAIL err_width: got %0d want 1", ce_max); end
    req(1'b0, 1'b1, 1'b1, 4'hF);
    wait_done(4000);
    go_idle();
    checks++; if (lens[1] !== exp_pp) begin errors++; $display("FAIL pause_prio_len: got %0d want %0d", lens[1], exp_pp); end
    checks++; if (ce_cnt - c0 !== 2) begin errors++; $display("FAIL err_count2: got %0d want 2", ce_cnt - c0); end
  endtask

  task automatic test_reset_mid();
    int p0;
    int f0;
    int rel;
    bool_wait: begin end
    clear_logs();
    req(1'b0, 1'b1, 1'b0, 4'd0);
    f0 = falls.size();
    for (int i = 0; i < 20 && falls.size() == f0; i++) begin
      @(negedge clk_tx);
      #1;
    end
    checks++; if (falls.size() === f0) begin errors++; $display("FAIL rst_first_fall: got none want 1"); end
    repeat (10) @(negedge clk_tx);
    #2;
    p0 = pd_cnt;
    reset_tx = 1'b1;
    #1;
    checks++; if (sent_out !== 1'b1) begin errors++; $display("FAIL rst_async_line: got %b want 1", sent_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk_tx);
    #1;
    reset_tx = 1'b0;
    rel = cyc;
    f0 = falls.size();
    for (int i = 0; i < 20 && falls.size() == f0; i++) begin
      @(negedge clk_tx);
      #1;
    end
    checks++; if (falls[falls.size() - 1] - rel !== 4) begin errors++; $display("FAIL rst_restart_delay: got %0d want 4", falls[falls.size() - 1] - rel); end
    wait_done(200);
    req(1'b0, 1'b0, 1'b0, 4'd0);
    go_idle();
    checks++; if (pd_cnt - p0 !== 1) begin errors++; $display("FAIL rst_pd_count: got %0d want 1", pd_cnt - p0); end
    checks++; if (lens[lens.size() - 1] !== 48) begin errors++; $display("FAIL rst_restart_len: got %0d want 48", lens[lens.size() - 1]); end
  endtask

  task automatic test_nibble_toggle();
    int p0;
    int f0;
    clear_logs();
    p0 = pd_cnt;
    f0 = falls.size();
    req(1'b0, 1'b1, 1'b0, 4'd7);
    for (int i = 0; i < 20 && falls.size() == f0; i++) begin
      @(negedge clk_tx);
      #1;
    end
    pulse = 1'b0;
    for (int i = 0; i < 200 && pd_cnt == p0; i++) begin
      data_nibble = 4'($urandom_range(0, 15));
      @(negedge clk_tx);
      #1;
    end
    go_idle();
    checks++; if (lens[0] !== 76) begin errors++; $display("FAIL toggle_len: got %0d want 76", lens[0]); end
    checks++; if (pd_cnt - p0 !== 1) begin errors++; $display("FAIL toggle_pd_count: got %0d want 1", pd_cnt - p0); end
  endtask

  initial begin
    test_reset();
    test_sync_nibble();
    test_frame();
    test_pause();
    test_cmd_err();
    test_reset_mid();
    test_nibble_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
